// File: rtl/i2s_rx_multi.sv
`default_nettype none
// ============================================================================
// Module   : i2s_rx_multi
// Summary  : Multi-line I2S microphone receiver. Generates BCLK/LRCLK and
//            delivers whole frames from NUM_LINES mics over valid/ready.
//            Optional macro I2S_RX_FRAME_CNT_EN adds a 16-bit loaded-frame count.
// Revision : 1.0  initial release
// ============================================================================
module i2s_rx_multi #(
  parameter int NUM_LINES        = 2,
  parameter int SAMPLE_WIDTH     = 24,
  parameter int BCLK_HALF_PERIOD = 12,
  parameter int MONO_MODE        = 0
) (
  input  logic                              clock_in,
  input  logic                              reset_in,
  output logic                              i2s_bclk_out,
  output logic                              i2s_lrclk_out,
  input  logic [NUM_LINES-1:0]              i2s_data_in,
  output logic [NUM_LINES*SAMPLE_WIDTH-1:0] left_sample_out,
  output logic [NUM_LINES*SAMPLE_WIDTH-1:0] right_sample_out,
  output logic                              sample_valid_out,
  input  logic                              sample_ready_in,
  output logic                              overflow_out
`ifdef I2S_RX_FRAME_CNT_EN
  ,
  output logic [15:0]                       frame_count_out
`endif
);

  localparam int                c_DIV_W    = $clog2(BCLK_HALF_PERIOD);
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(BCLK_HALF_PERIOD - 1);
  localparam int                c_OUT_W    = NUM_LINES * SAMPLE_WIDTH;

  logic [c_DIV_W-1:0]   r_div_cnt;
  logic                 r_bclk;
  logic                 r_lrclk;
  logic [5:0]           r_bit_cnt;
  logic                 r_frame_done;
  logic [NUM_LINES-1:0] r_sync1;
  logic [NUM_LINES-1:0] r_sync2;
  logic [c_OUT_W-1:0]   r_left;
  logic [c_OUT_W-1:0]   r_right;
  logic                 r_valid;
  logic                 r_overflow;

  logic                 w_div_tc;
  logic                 w_rise;
  logic                 w_fall;
  logic [5:0]           w_bit_nxt;
  logic [4:0]           w_slot;
  logic                 w_cap;
  logic                 w_cap_l;
  logic                 w_cap_r;
  logic                 w_load;
  logic [c_OUT_W-1:0]   w_frame_l;
  logic [c_OUT_W-1:0]   w_frame_r;

  assign w_div_tc  = (r_div_cnt == c_DIV_LAST);
  assign w_rise    = w_div_tc & ~r_bclk;
  assign w_fall    = w_div_tc & r_bclk;
  assign w_bit_nxt = r_bit_cnt + 6'd1;

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      r_div_cnt <= '0;
      r_bclk    <= 1'b0;
    end else if (w_div_tc) begin
      r_div_cnt <= '0;
      r_bclk    <= ~r_bclk;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  // LRCLK follows the bit counter so it always changes on a BCLK fall.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      r_bit_cnt    <= '0;
      r_lrclk      <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_fall && (r_bit_cnt == 6'd63);
      if (w_fall) begin
        r_bit_cnt <= w_bit_nxt;
        r_lrclk   <= w_bit_nxt[5];
      end
    end
  end

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i2s_data_in;
      r_sync2 <= r_sync1;
    end
  end

  // Slot bit 0 is the I2S one-bit delay; bits past the sample width are padding.
  assign w_slot  = r_bit_cnt[4:0];
  assign w_cap   = w_rise && (w_slot != 5'd0) && (int'(w_slot) <= SAMPLE_WIDTH);
  assign w_cap_l = w_cap & ~r_bit_cnt[5];
  assign w_cap_r = w_cap & r_bit_cnt[5] & (MONO_MODE == 0);

  generate
    for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_line
      logic [SAMPLE_WIDTH-1:0] r_sh_l;
      logic [SAMPLE_WIDTH-1:0] r_sh_r;

      always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
          r_sh_l <= '0;
          r_sh_r <= '0;
        end else begin
          if (w_cap_l) r_sh_l <= {r_sh_l[SAMPLE_WIDTH-2:0], r_sync2[gi]};
          if (w_cap_r) r_sh_r <= {r_sh_r[SAMPLE_WIDTH-2:0], r_sync2[gi]};
        end
      end

      assign w_frame_l[gi*SAMPLE_WIDTH +: SAMPLE_WIDTH] = r_sh_l;
      assign w_frame_r[gi*SAMPLE_WIDTH +: SAMPLE_WIDTH] = r_sh_r;
    end
  endgenerate

  // A completed frame loads only if the output slot is empty or being drained now.
  assign w_load = r_frame_done & (~r_valid | sample_ready_in);

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      r_left     <= '0;
      r_right    <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
    end else if (w_load) begin
      r_left  <= w_frame_l;
      r_right <= w_frame_r;
      r_valid <= 1'b1;
    end else if (r_frame_done) begin
      r_overflow <= 1'b1;
    end else if (r_valid && sample_ready_in) begin
      r_valid <= 1'b0;
    end
  end

`ifdef I2S_RX_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      r_frame_cnt <= '0;
    end else if (w_load) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign frame_count_out = r_frame_cnt;
`endif

  assign i2s_bclk_out     = r_bclk;
  assign i2s_lrclk_out    = r_lrclk;
  assign left_sample_out  = r_left;
  assign right_sample_out = r_right;
  assign sample_valid_out = r_valid;
  assign overflow_out     = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_i2s_rx_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_rx_multi
// Summary  : Directed bench for i2s_rx_multi: a stereo 2-line instance and a
//            mono 1-line instance driven by a behavioural I2S mic model.
// Revision : 1.0  initial release
// ============================================================================
module tb_i2s_rx_multi;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  d_main;
  logic [0:0]  d_mono;
  logic        ready = 1'b1;
  logic        mono_ready = 1'b1;

  logic        bclk, lrclk, valid, ovf;
  logic [47:0] left, right;
  logic        m_bclk, m_lrclk, m_valid, m_ovf;
  logic [23:0] m_left, m_right;
`ifdef I2S_RX_FRAME_CNT_EN
  logic [15:0] fcnt, m_fcnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Mic model state: index 0/1 feed the stereo instance, index 2 the mono one.
  logic [23:0] lv [3];
  logic [23:0] rv [3];
  logic [5:0]  mcnt = 6'd0;

  always #5 clk = ~clk;

  i2s_rx_multi #(.NUM_LINES(2), .SAMPLE_WIDTH(24), .BCLK_HALF_PERIOD(12), .MONO_MODE(0)) u_dut (
    .clock_in        (clk),
    .reset_in        (rst),
    .i2s_bclk_out    (bclk),
    .i2s_lrclk_out   (lrclk),
    .i2s_data_in     (d_main),
    .left_sample_out (left),
    .right_sample_out(right),
    .sample_valid_out(valid),
    .sample_ready_in (ready),
    .overflow_out    (ovf)
`ifdef I2S_RX_FRAME_CNT_EN
    ,
    .frame_count_out (fcnt)
`endif
  );

  i2s_rx_multi #(.NUM_LINES(1), .SAMPLE_WIDTH(24), .BCLK_HALF_PERIOD(12), .MONO_MODE(1)) u_mono (
    .clock_in        (clk),
    .reset_in        (rst),
    .i2s_bclk_out    (m_bclk),
    .i2s_lrclk_out   (m_lrclk),
    .i2s_data_in     (d_mono),
    .left_sample_out (m_left),
    .right_sample_out(m_right),
    .sample_valid_out(m_valid),
    .sample_ready_in (mono_ready),
    .overflow_out    (m_ovf)
`ifdef I2S_RX_FRAME_CNT_EN
    ,
    .frame_count_out (m_fcnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Slot bits 1..24 carry the sample MSB first; delay bit and padding are driven 1.
  function automatic logic mic_bit(input int i);
    int k;
    k = int'(mcnt[4:0]);
    if (k >= 1 && k <= 24) return mcnt[5] ? rv[i][24-k] : lv[i][24-k];
    return 1'b1;
  endfunction

  task automatic drive_mics();
    d_main = {mic_bit(1), mic_bit(0)};
    d_mono = mic_bit(2);
  endtask

  initial begin
    forever begin
      @(negedge bclk or posedge rst);
      if (rst) mcnt = 6'd0;
      else     mcnt = mcnt + 6'd1;
      drive_mics();
    end
  end

  // Clock-shape monitor: BCLK and LRCLK rising-edge intervals, and LRCLK edges off a BCLK fall.
  int cyc = 0, last_br = -1, last_lr = -1, bclk_per = 0, lr_per = 0, lr_bad = 0;
  logic pb = 1'b0, plr = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (bclk && !pb) begin
        if (last_br >= 0) bclk_per = cyc - last_br;
        last_br = cyc;
      end
      if (lrclk && !plr) begin
        if (last_lr >= 0) lr_per = cyc - last_lr;
        last_lr = cyc;
      end
      if (lrclk != plr && !(pb && !bclk)) lr_bad++;
      pb  = bclk;
      plr = lrclk;
    end
  end

  task automatic wait_valid(input string tag, input int budget, output int n);
    n = 0;
    while (!valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, valid, 1'b1);
  endtask

  task automatic set_line(input int i, input logic [23:0] l, input logic [23:0] r);
    lv[i] = l;
    rv[i] = r;
  endtask

  initial begin
    int n;
    set_line(0, 24'hA5A5A5, 24'h123456);
    set_line(1, 24'h800001, 24'h7FFFFF);
    set_line(2, 24'h3C5A96, 24'hFFFFFF);
    drive_mics();
    ready = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_left",  left,  48'h0);
    check("rst_right", right, 48'h0);
    check("rst_valid", valid, 1'b0);
    check("rst_ovf",   ovf,   1'b0);
    check("rst_bclk",  bclk,  1'b0);
    check("rst_lrclk", lrclk, 1'b0);
`ifdef I2S_RX_FRAME_CNT_EN
    check("rst_fcnt",  fcnt,  16'd0);
`endif

    rst = 1'b0;
    wait_valid("f1_to", 3000, n);
    check("f1_latency_win", (n >= 1536 && n <= 1538), 1'b1);
    check("f1_l0", left[23:0],   24'hA5A5A5);
    check("f1_r0", right[23:0],  24'h123456);
    check("f1_l1", left[47:24],  24'h800001);
    check("f1_r1", right[47:24], 24'h7FFFFF);
    check("mono_valid", m_valid, 1'b1);
    check("mono_left",  m_left,  24'h3C5A96);
    check("mono_right", m_right, 24'h0);
`ifdef I2S_RX_FRAME_CNT_EN
    check("f1_fcnt", fcnt, 16'd1);
`endif
    set_line(0, 24'h111111, 24'h222222);
    set_line(1, 24'h333333, 24'h444444);
    @(negedge clk);
    check("f1_pulse", valid, 1'b0);
    ready = 1'b0;

    wait_valid("f2_to", 3000, n);
    check("bclk_period",  bclk_per, 24);
    check("lrclk_period", lr_per,   1536);
    check("lrclk_on_fall", lr_bad,  0);
    check("f2_l0", left[23:0],   24'h111111);
    check("f2_r1", right[47:24], 24'h444444);
    set_line(0, 24'h555555, 24'h0F0F0F);

    n = 0;
    while (!ovf && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("ovf_set",   ovf,          1'b1);
    check("ovf_valid", valid,        1'b1);
    check("ovf_hold_l0", left[23:0],   24'h111111);
    check("ovf_hold_r0", right[23:0],  24'h222222);
    check("ovf_hold_l1", left[47:24],  24'h333333);
    set_line(0, 24'h666666, 24'h777777);
    ready = 1'b1;
    @(negedge clk);
    check("drain_valid", valid, 1'b0);
    check("ovf_sticky",  ovf,   1'b1);

    wait_valid("f4_to", 3000, n);
    check("f4_l0", left[23:0],  24'h666666);
    check("f4_r0", right[23:0], 24'h777777);
`ifdef I2S_RX_FRAME_CNT_EN
    check("f4_fcnt", fcnt, 16'd3);
`endif
    @(negedge clk);
    check("f4_pulse", valid, 1'b0);

    n = 0;
    while (mcnt != 6'd40 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("bit40_reached", mcnt, 6'd40);
    rst = 1'b1;
    #1;
    check("ar_left",  left,  48'h0);
    check("ar_right", right, 48'h0);
    check("ar_valid", valid, 1'b0);
    check("ar_ovf",   ovf,   1'b0);
    check("ar_lrclk", lrclk, 1'b0);
`ifdef I2S_RX_FRAME_CNT_EN
    check("ar_fcnt",  fcnt,  16'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    wait_valid("f5_to", 3000, n);
    check("f5_latency_win", (n >= 1536 && n <= 1538), 1'b1);
    check("f5_l0", left[23:0],   24'h666666);
    check("f5_r1", right[47:24], 24'h444444);
`ifdef I2S_RX_FRAME_CNT_EN
    check("f5_fcnt", fcnt, 16'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
